// File: rtl/mdu_divider_if.sv
// Request/response bus between the execute stage and the iterative divider.
// The master side issues operations and consumes results; the divider is the slave.
interface mdu_divider_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_op;
  logic [XLEN-1:0] in_1;
  logic [XLEN-1:0] in_2;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output req_valid, req_op, in_1, in_2, resp_ready,
    input  req_ready, resp_valid, result, busy
  );

  modport slave (
    input  req_valid, req_op, in_1, in_2, resp_ready,
    output req_ready, resp_valid, result, busy
  );
endinterface

// File: rtl/mdu_divider.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Divide-by-zero and signed overflow bypass the iteration and answer on the next cycle.
module mdu_divider #(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  mdu_divider_if.slave bus
);

  localparam int CNT_W = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [XLEN-1:0] ONE     = XLEN'(1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONE = '1;

  logic [1:0]      state_q, state_d;
  logic            sel_rem_q, sel_rem_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;
  logic [XLEN-1:0] dvd_q, dvd_d;
  logic [XLEN-1:0] dsr_q, dsr_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic            accept;
  logic            sgn_op;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;
  logic            qbit;

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic en);
    return en ? (~v) + ONE : v;
  endfunction

  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic is_signed);
    return cond_neg(v, is_signed & v[XLEN-1]);
  endfunction

  assign accept = (state_q == S_IDLE) && bus.req_valid && !flush;
  assign sgn_op = ~bus.req_op[0];

  // Trial subtraction is done at XLEN+1 bits so the top bit is the borrow.
  assign rem_sh = {rem_q, dvd_q[XLEN-1]};
  assign diff   = rem_sh - {1'b0, dsr_q};
  assign qbit   = ~diff[XLEN];

  always_comb begin
    state_d   = state_q;
    sel_rem_d = sel_rem_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    rem_d     = rem_q;
    res_d     = res_q;
    cnt_d     = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          sel_rem_d = bus.req_op[1];
          negq_d    = sgn_op & (bus.in_1[XLEN-1] ^ bus.in_2[XLEN-1]);
          negr_d    = sgn_op & bus.in_1[XLEN-1];
          dvd_d     = abs_val(bus.in_1, sgn_op);
          dsr_d     = abs_val(bus.in_2, sgn_op);
          rem_d     = '0;
          cnt_d     = CNT_W'(XLEN - 1);
          if (bus.in_2 == '0) begin
            res_d   = bus.req_op[1] ? bus.in_1 : ALL_ONE;
            state_d = S_DONE;
          end else if (sgn_op && bus.in_1 == INT_MIN && bus.in_2 == ALL_ONE) begin
            res_d   = bus.req_op[1] ? '0 : INT_MIN;
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        rem_d = qbit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        dvd_d = {dvd_q[XLEN-2:0], qbit};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_FIX: begin
        res_d   = sel_rem_q ? cond_neg(rem_q, negr_q) : cond_neg(dvd_q, negq_q);
        state_d = S_DONE;
      end
      default: begin
        if (bus.resp_ready) begin
          res_d   = '0;
          state_d = S_IDLE;
        end
      end
    endcase

    // Abort wins over any handshake; the result bus must read zero outside DONE.
    if (flush) begin
      state_d = S_IDLE;
      res_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sel_rem_q <= 1'b0;
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sel_rem_q <= sel_rem_d;
      negq_q    <= negq_d;
      negr_q    <= negr_d;
      dvd_q     <= dvd_d;
      dsr_q     <= dsr_d;
      rem_q     <= rem_d;
      res_q     <= res_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_DONE);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.result     = res_q;

endmodule

// File: tb/tb_mdu_divider.sv
// Randomized and directed bench for mdu_divider against an arithmetic RV32M division model.
module tb_mdu_divider;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  mdu_divider_if #(.XLEN(32)) bus ();

  mdu_divider #(.XLEN(32)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // RV32M semantics straight from the ISA rules using native signed/unsigned division.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      sa = $signed(a);
      sb = $signed(b);
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
      return op[1] ? (sa % sb) : (sa / sb);
    end
    return op[1] ? (a % b) : (a / b);
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      6: return 32'd0 - 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    chk("req_ready_before_issue", {31'd0, bus.req_ready}, 32'd1);
    bus.req_op    = op;
    bus.in_1      = a;
    bus.in_2      = b;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.in_1      = $urandom;
    bus.in_2      = $urandom;
  endtask

  task automatic wait_resp(output int lat);
    lat = 1;
    while (!bus.resp_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic finish_resp(input string tag, input int hold, input logic [31:0] exp_res);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_valid"}, {31'd0, bus.resp_valid}, 32'd1);
      chk({tag, "_hold_result"}, bus.result, exp_res);
    end
    @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    chk({tag, "_valid_drop"}, {31'd0, bus.resp_valid}, 32'd0);
    chk({tag, "_result_clear"}, bus.result, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    int lat;
    logic [31:0] exp_res;
    exp_res = ref_div(op, a, b);
    issue(op, a, b);
    wait_resp(lat);
    chk({tag, "_lat"}, lat, ref_lat(op, a, b));
    chk(tag, bus.result, exp_res);
    finish_resp(tag, hold, exp_res);
  endtask

  initial begin
    int lat;
    int seen;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    rst            = 1'b1;
    flush          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_op     = 2'b00;
    bus.in_1       = '0;
    bus.in_2       = '0;
    bus.resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);

    run_op("div_20_3", 2'b00, 32'd20, 32'd3, 0);
    run_op("rem_20_3", 2'b10, 32'd20, 32'd3, 0);
    run_op("div_m20_3", 2'b00, 32'hFFFF_FFEC, 32'd3, 0);
    run_op("rem_m20_3", 2'b10, 32'hFFFF_FFEC, 32'd3, 0);
    run_op("rem_20_m3", 2'b10, 32'd20, 32'hFFFF_FFFD, 0);
    run_op("divu_max_2", 2'b01, 32'hFFFF_FFFF, 32'd2, 0);
    run_op("remu_max_2", 2'b11, 32'hFFFF_FFFF, 32'd2, 0);
    run_op("div_7_0", 2'b00, 32'd7, 32'd0, 0);
    run_op("rem_7_0", 2'b10, 32'd7, 32'd0, 0);
    run_op("divu_min_0", 2'b01, 32'h8000_0000, 32'd0, 0);
    run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("divu_ovf_ops", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 0);

    // Backpressure with a request already waiting when the response is taken
    issue(2'b01, 32'hFFFF_FFFF, 32'd2);
    wait_resp(lat);
    chk("bp_lat", lat, 32'd34);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", {31'd0, bus.resp_valid}, 32'd1);
      chk("bp_result", bus.result, 32'h7FFF_FFFF);
      chk("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
    end
    @(negedge clk);
    bus.resp_ready = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_op     = 2'b10;
    bus.in_1       = 32'd20;
    bus.in_2       = 32'd3;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    chk("bp_idle_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("bp_idle_ready", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    wait_resp(lat);
    chk("bp_next_lat", lat, 32'd34);
    chk("bp_next_result", bus.result, 32'd2);
    finish_resp("bp_next", 0, 32'd2);

    // Flush in the middle of CALC
    issue(2'b00, 32'd1000, 32'd3);
    repeat (14) begin
      @(posedge clk);
      #1;
    end
    chk("calc_result_zero", bus.result, 32'd0);
    chk("calc_busy", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_busy", {31'd0, bus.busy}, 32'd0);
    chk("flush_req_ready", {31'd0, bus.req_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.resp_valid) seen++;
    end
    chk("flush_no_resp", seen, 32'd0);
    run_op("div_100_7", 2'b00, 32'd100, 32'd7, 0);

    // Flush while a request is offered in IDLE must block acceptance
    @(negedge clk);
    flush         = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b00;
    bus.in_1      = 32'd9;
    bus.in_2      = 32'd2;
    @(posedge clk);
    #1;
    flush         = 1'b0;
    bus.req_valid = 1'b0;
    chk("flush_idle_busy", {31'd0, bus.busy}, 32'd0);

    // Reset in the middle of an operation
    issue(2'b01, 32'd12345, 32'd17);
    repeat (19) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("midrst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("midrst_result", bus.result, 32'd0);
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);

    // Random sweep biased toward corner operands
    for (int n = 0; n < 60; n++) begin
      op = 2'($urandom_range(0, 3));
      a  = pick_operand();
      b  = pick_operand();
      if ($urandom_range(0, 9) == 0) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      run_op("rand", op, a, b, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
